// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_AE_TH = 2;

  // Count needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointers, accept logic, occupancy count and registered status flags.
// Flags follow the next count, so they change on the same edge as data_count.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = DEF_AE_TH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic                       clr_err,
  output logic                       wr_acc,
  output logic                       rd_acc,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fifo_status_t     st_q, st_d;

  always_comb begin
    rd_acc   = rd_en & ~st_q.empty;
    // A pop in the same cycle frees the slot a write into a full FIFO needs.
    wr_acc   = wr_en & (~st_q.full | rd_acc);
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_W'(1);
    end

    st_d.full         = (count_d == CNT_W'(DEPTH));
    st_d.empty        = (count_d == '0);
    st_d.almost_full  = (count_d >= CNT_W'(AF_TH));
    st_d.almost_empty = (count_d <= CNT_W'(AE_TH));
    // A new error in the same cycle as clr_err keeps the flag set.
    st_d.overflow     = (wr_en & ~wr_acc) | (st_q.overflow & ~clr_err);
    st_d.underflow    = (rd_en & ~rd_acc) | (st_q.underflow & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      st_q     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                    almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      st_q     <= st_d;
    end
  end

  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign full         = st_q.full;
  assign empty        = st_q.empty;
  assign almost_full  = st_q.almost_full;
  assign almost_empty = st_q.almost_empty;
  assign overflow     = st_q.overflow;
  assign underflow    = st_q.underflow;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO: storage array plus standard (1-cycle registered read)
// or first-word-fall-through output stage; full rejects writes unless a pop frees a slot.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_TH  = DEPTH - 2,
  parameter int AE_TH  = DEF_AE_TH,
  parameter bit FWFT   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    data_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_w(DEPTH)-1:0] data_count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two in 4..1024");
  end
  if (AE_TH >= AF_TH) begin : g_bad_th
    $error("fifo_sync_param: AE_TH must be below AF_TH");
  end
  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
    $error("fifo_sync_param: DATA_W must be in 1..64");
  end

  logic             wr_acc, rd_acc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  fifo_ptr_ctrl #(.DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .wr_acc       (wr_acc),
    .rd_acc       (rd_acc),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (data_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  if (FWFT) begin : g_fwft
    // Gated while empty so the unwritten head never reaches the output.
    assign data_out   = empty ? '0 : mem[rd_ptr];
    assign data_valid = ~empty;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvld_q, dvld_d;

    always_comb begin
      dout_d = rd_acc ? mem[rd_ptr] : dout_q;
      dvld_d = rd_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
        dvld_q <= 1'b0;
      end else begin
        dout_q <= dout_d;
        dvld_q <= dvld_d;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dvld_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: standard-mode instance checked cycle by cycle
// against a queue scoreboard, plus a small FWFT-mode instance.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode DUT
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] data_count;

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .data_count(data_count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  // FWFT-mode DUT
  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_din = '0;
  logic [7:0] f_dout;
  logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_cnt;

  fifo_sync_param #(.DATA_W(8), .DEPTH(16), .FWFT(1'b1)) dut_f (
    .clk(clk), .rst(rst), .wr_en(f_wr), .rd_en(f_rd), .data_in(f_din),
    .data_out(f_dout), .data_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .data_count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(1'b0)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0, m_unf = 1'b0, m_dv = 1'b0;
  logic [7:0] m_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dv = 1'b0; m_dout = '0;
  endtask

  task automatic check_all(input string where);
    chk({where, ".count"}, 32'(data_count), 32'(m_cnt));
    chk({where, ".full"}, 32'(full), 32'(m_cnt == 16));
    chk({where, ".empty"}, 32'(empty), 32'(m_cnt == 0));
    chk({where, ".afull"}, 32'(almost_full), 32'(m_cnt >= 14));
    chk({where, ".aempty"}, 32'(almost_empty), 32'(m_cnt <= 2));
    chk({where, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({where, ".unf"}, 32'(underflow), 32'(m_unf));
    chk({where, ".dvalid"}, 32'(data_valid), 32'(m_dv));
    chk({where, ".dout"}, 32'(data_out), 32'(m_dout));
  endtask

  // One clock of stimulus: scoreboard updated at drive time, outputs checked after the edge.
  task automatic cycle(input string where, input logic we, input logic re,
                       input logic clr, input logic [7:0] din);
    logic racc, wacc;
    wr_en = we; rd_en = re; clr_err = clr; data_in = din;
    racc  = re && (m_cnt > 0);
    wacc  = we && ((m_cnt < 16) || racc);
    m_ovf = (we && !wacc) || (m_ovf && !clr);
    m_unf = (re && !racc) || (m_unf && !clr);
    m_dv  = racc;
    if (racc) m_dout = q.pop_front();
    if (wacc) q.push_back(din);
    m_cnt = q.size();
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    check_all(where);
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("f_reset.dout", 32'(f_dout), 32'h0);
    chk("f_reset.dvalid", 32'(f_dv), 32'h0);
    chk("f_reset.empty", 32'(f_empty), 32'h1);
    rst = 1'b1;

    // Fill 0x01..0x10, then write while full
    for (int i = 1; i <= 16; i++) cycle("fill", 1'b1, 1'b0, 1'b0, 8'(i));
    cycle("wr_full", 1'b1, 1'b0, 1'b0, 8'hAA);
    cycle("clr_ovf", 1'b0, 1'b0, 1'b1, 8'h00);

    // Drain: 0x01..0x10 in order, one cycle after rd_en
    for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 1'b1, 1'b0, 8'h00);

    // Read on empty together with a write
    cycle("rd_empty_wr", 1'b1, 1'b1, 1'b0, 8'h55);
    cycle("clr_unf", 1'b0, 1'b0, 1'b1, 8'h00);

    // Refill, then sustained push/pop at full across pointer wrap
    for (int i = 0; i < 15; i++) cycle("refill", 1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) cycle("wr_rd_full", 1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 16; i++) cycle("drain2", 1'b0, 1'b1, 1'b0, 8'h00);

    // FWFT: head appears without rd_en, pops advance the head
    f_wr = 1'b1; f_din = 8'h3C;
    @(posedge clk); #1;
    f_wr = 1'b0;
    chk("fwft_wr.dout", 32'(f_dout), 32'h3C);
    chk("fwft_wr.dvalid", 32'(f_dv), 32'h1);
    chk("fwft_wr.empty", 32'(f_empty), 32'h0);
    f_wr = 1'b1; f_din = 8'h4D;
    @(posedge clk); #1;
    f_wr = 1'b0;
    chk("fwft_wr2.dout", 32'(f_dout), 32'h3C);
    chk("fwft_wr2.count", 32'(f_cnt), 32'h2);
    f_rd = 1'b1;
    @(posedge clk); #1;
    chk("fwft_pop1.dout", 32'(f_dout), 32'h4D);
    chk("fwft_pop1.dvalid", 32'(f_dv), 32'h1);
    @(posedge clk); #1;
    f_rd = 1'b0;
    chk("fwft_pop2.empty", 32'(f_empty), 32'h1);
    chk("fwft_pop2.dvalid", 32'(f_dv), 32'h0);
    chk("fwft_pop2.unf", 32'(f_unf), 32'h0);

    // Asynchronous reset in the middle of a burst at count 7
    for (int i = 0; i < 7; i++) cycle("burst", 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    cycle("post_rst_wr", 1'b1, 1'b0, 1'b0, 8'h77);
    cycle("post_rst_rd", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("post_rst_idle", 1'b0, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; next generation of the board-level FIFO block.
- Generalised in data width and depth.
- Adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between the single-cycle button pulse generators (or any producer/consumer) and the display path; single clock domain, no internal clock generation.

Parameters:
- DATA_W, 8, data word width in bits (1..64).
- DEPTH, 16, number of storage words; power of two, 4..1024.
- AF_TH, DEPTH-2, almost_full asserts when count >= AF_TH.
- AE_TH, 2, almost_empty asserts when count <= AE_TH.
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous active-low reset (0 = reset asserted); release is taken as synchronous to clk upstream.
- wr_en  in  1  write request, one word per cycle while high.
- rd_en  in  1  read request (standard) / pop acknowledge (FWFT).
- data_in  in  DATA_W  write data, sampled on accepted write.
- data_out  out  DATA_W  read data.
- data_valid  out  1  data_out holds a valid popped word (standard) / head word present (FWFT).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_TH.
- almost_empty  out  1  count <= AE_TH.
- data_count  out  $clog2(DEPTH)+1  words currently stored, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count are 0.
  - data_out = 0, data_valid = 0, empty = 1, almost_empty = 1.
  - full, almost_full, overflow and underflow = 0.
  - Memory contents are not reset.
- Storage and pointers:
  - Memory is DEPTH x DATA_W.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Accepted write: wr_acc = wr_en & ~full, OR wr_en & full & rd_acc (simultaneous pop frees a slot).
- Accepted read: rd_acc = rd_en & ~empty.
- Count update per cycle:
  - +1 on write only, -1 on read only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH or goes below 0.
- All flags are registered, computed from the next count, so they are valid the same edge the count changes.
- Simultaneous read and write when empty: read rejected (underflow set), write accepted, count becomes 1.
- Simultaneous read and write when full: both accepted, count stays DEPTH, full stays 1, overflow not set.
- Error flags:
  - overflow is set on wr_en & ~wr_acc; underflow is set on rd_en & ~rd_acc.
  - Both are sticky until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the set wins.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at that edge, and data_valid=1 for exactly the following cycle.
  - Otherwise data_valid=0 and data_out holds its last value.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - data_out continuously shows mem[rd_ptr]; data_valid = ~empty.
  - rd_en pops the head; the next word appears the cycle after the pop.
  - A word written into an empty FIFO appears on data_out one cycle after the write edge.
- Write/read same-address hazard: only possible when count is 0 or DEPTH; covered by the rules above (no read-through of unwritten data).
- Parameter check: elaboration error if DEPTH is not a power of two or if AE_TH >= AF_TH.

Decomposition:
- Package fifo_pkg:
  - function clog2-based CNT_W(depth).
  - typedef for the fifo status struct {full, empty, almost_full, almost_empty, overflow, underflow}.
  - default threshold constants.
- One sub-module, fifo_ptr_ctrl: pointers, accept logic, count, flags and error stickiness.
- Top: memory array plus the FWFT/standard output stage.

Test Plan:
- DATA_W=8, DEPTH=16, FWFT=0: reset; write 0x01..0x10 -> full=1 after 16th write, data_count=16, almost_full=1 from count 14.
- Then read 16 words -> data_out = 0x01..0x10 in order, each one cycle after rd_en, data_valid pulses; empty=1 at the end.
- Write on full (0xAA) -> overflow=1, data_count stays 16, stored data unchanged; clr_err -> overflow=0.
- Read when empty -> underflow=1, data_valid=0. Same cycle wr_en with 0x55 -> count=1.
- Simultaneous wr/rd at full for 20 cycles with incrementing data -> count stays 16, full stays 1, no overflow, pointers wrap, output order preserved.
- FWFT=1: write 0x3C into empty -> data_out=0x3C and data_valid=1 one cycle later without rd_en; rd_en -> empty=1.
- Assert rst=0 mid-burst at count=7 asynchronously -> all flags and the count drop immediately to reset values; after release, a new write/read returns new data, not stale data.
